multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the MIPS datapath: a Moore FSM plus memory wait-state handling. It walks each instruction through fetch, decode, execute, memory and writeback over 3–5 cycles, not counting memory wait states. It drives every datapath enable, mux select and the 3-bit Aluop consumed by the ALU control. It serves the shared single-port instruction/data memory, the register file and the PC/IR registers.

## Interface
- No parameters.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Op  in  6  opcode, IR[31:26]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if Zero
- PCSource  out  1  0 = ALU result, 1 = ALUOut (branch target)
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead, MemWrite  out  1 each  memory strobes
- IRWrite  out  1  IR load
- RegDst  out  1  1 = rd, 0 = rt
- RegWr  out  1  register file write
- MemToReg  out  1  1 = MDR, 0 = ALUOut
- AluSrcA  out  1  0 = PC, 1 = rs
- AluSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
- Aluop  out  3  000 R-type (funct), 001 add, 010 addi, 011 andi, 100 sub (beq)
- Illegal  out  1  one-cycle pulse on an unsupported opcode
- State  out  4  current state, for debug

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, IEXEC 8, IWB 9, BRANCH 10, ILLEGAL 11. Codes 12–15 go to FETCH on the next edge with all outputs 0.
- Any output not listed for a state is 0.
- **FETCH:**
  - Outputs: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, Aluop=001.
  - IRWrite=1 and PCWrite=1 only while MemReady=1; these are the only Mealy outputs.
  - Stays in FETCH until MemReady=1, then goes to DECODE.
- **DECODE:**
  - Outputs: AluSrcA=0, AluSrcB=11, Aluop=001.
  - Next state by Op:
    - 000000 → EXEC
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 001000 (addi) or 001100 (andi) → IEXEC
    - 000100 (beq) → BRANCH
    - anything else → ILLEGAL
- **MEMADR:** AluSrcA=1, AluSrcB=10, Aluop=001. Op=100011 → MEMRD, else → MEMWR.
- **MEMRD:** MemRead=1, IorD=1. Held until MemReady=1, then → MEMWB.
- **MEMWB:** RegWr=1, RegDst=0, MemToReg=1. Then → FETCH.
- **MEMWR:** MemWrite=1, IorD=1. Held until MemReady=1, then → FETCH.
- **EXEC:** AluSrcA=1, AluSrcB=00, Aluop=000. Then → RWB.
- **RWB:** RegWr=1, RegDst=1, MemToReg=0. Then → FETCH.
- **IEXEC:** AluSrcA=1, AluSrcB=10. Aluop=010 for addi, 011 for andi, decoded from Op, which is held by IR. Then → IWB.
- **IWB:** RegWr=1, RegDst=0, MemToReg=0. Then → FETCH.
- **BRANCH:** AluSrcA=1, AluSrcB=00, Aluop=100, PCWriteCond=1, PCSource=1. Then → FETCH.
- **ILLEGAL:** Illegal=1 for exactly this cycle, then → FETCH. The PC already advanced by 4, so the instruction behaves as a NOP.
- MemRead and MemWrite are never both 1. RegWr and any memory strobe are never both 1.

## Timing
- Reset:
  - rst_n low: the state register is asynchronously forced to FETCH.
  - All outputs, including the Mealy IRWrite/PCWrite, are gated to 0 and State=0.
  - First MemRead=1 is visible in the first cycle with rst_n high.
- Transitions occur on the rising clk edge. Outputs decode from state (plus MemReady in FETCH) in the same cycle.
- Minimum cycles per instruction with MemReady tied high:
  - beq 3
  - R-type, addi, andi and sw 4
  - lw 5
  - illegal 3
- Each cycle MemReady is low in FETCH, MEMRD or MEMWR adds one cycle. Strobes stay asserted and IorD stays stable throughout the wait.
- MemReady outside those three states is ignored.
- rst_n asserted mid-instruction (including during a wait): outputs drop to 0 immediately. The partial instruction is abandoned with no write strobes after assertion, and the FSM restarts in FETCH.

## Test plan
- Reset: rst_n=0 with MemReady=1 → all outputs 0 and State=0. Release rst_n → the first cycle shows MemRead=1, IRWrite=1, PCWrite=1.
- R-type, Op=000000, MemReady=1 → State sequence 0,1,6,7,0. In state 6, Aluop=000. In state 7, RegWr=1 and RegDst=1.
- lw with MemReady low for 2 cycles in FETCH and 3 cycles in MEMRD → sequence 0,0,0,1,2,3,3,3,3,4,0.
  - In every FETCH cycle, MemRead=1.
  - IRWrite=1 only in the third FETCH cycle.
  - In state 4, RegWr=1 and MemToReg=1.
- sw, Op=101011 → 0,1,2,5,0. MemWrite=1 and IorD=1 in state 5, with RegWr=0 throughout. beq → 0,1,10,0 with PCWriteCond=1 and Aluop=100, checked for both Zero=0 and Zero=1.
- addi/andi, Op=001000 then Op=001100 → state 8 shows Aluop=010, then 011. State 9 shows RegWr=1 and RegDst=0.
- Edge cases:
  - Op=111111 → 0,1,11,0 with Illegal high for exactly one cycle.
  - rst_n pulsed low during MEMWR → MemWrite drops immediately and State=0.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with memory wait states
// Moore sequencer; IRWrite/PCWrite in FETCH additionally wait on MemReady.
module multicycle_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Op,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       PCSource,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       RegWr,
   output logic       MemToReg,
   output logic       AluSrcA,
   output logic [1:0] AluSrcB,
   output logic [2:0] Aluop,
   output logic       Illegal,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXEC    = 4'd6,
      RWB     = 4'd7,
      IEXEC   = 4'd8,
      IWB     = 4'd9,
      BRANCH  = 4'd10,
      ILLEGAL = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   state_t state;
   state_t nextState;

   logic       pcWriteC;
   logic       pcWriteCondC;
   logic       pcSourceC;
   logic       iorDC;
   logic       memReadC;
   logic       memWriteC;
   logic       irWriteC;
   logic       regDstC;
   logic       regWrC;
   logic       memToRegC;
   logic       aluSrcAC;
   logic [1:0] aluSrcBC;
   logic [2:0] aluopC;
   logic       illegalC;

   // The Zero qualification of PCWriteCond happens in the datapath, not here.
   logic unusedZero;
   assign unusedZero = Zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState    = FETCH;
      pcWriteC     = 1'b0;
      pcWriteCondC = 1'b0;
      pcSourceC    = 1'b0;
      iorDC        = 1'b0;
      memReadC     = 1'b0;
      memWriteC    = 1'b0;
      irWriteC     = 1'b0;
      regDstC      = 1'b0;
      regWrC       = 1'b0;
      memToRegC    = 1'b0;
      aluSrcAC     = 1'b0;
      aluSrcBC     = 2'b00;
      aluopC       = 3'b000;
      illegalC     = 1'b0;

      case (state)
         FETCH: begin
            memReadC = 1'b1;
            aluSrcBC = 2'b01;
            aluopC   = 3'b001;
            irWriteC = MemReady;
            pcWriteC = MemReady;
            nextState = MemReady ? DECODE : FETCH;
         end
         DECODE: begin
            // Branch target PC + (imm<<2) is computed speculatively here.
            aluSrcBC = 2'b11;
            aluopC   = 3'b001;
            case (Op)
               OP_RTYPE:        nextState = EXEC;
               OP_LW, OP_SW:    nextState = MEMADR;
               OP_ADDI, OP_ANDI: nextState = IEXEC;
               OP_BEQ:          nextState = BRANCH;
               default:         nextState = ILLEGAL;
            endcase
         end
         MEMADR: begin
            aluSrcAC  = 1'b1;
            aluSrcBC  = 2'b10;
            aluopC    = 3'b001;
            nextState = (Op == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            memReadC  = 1'b1;
            iorDC     = 1'b1;
            nextState = MemReady ? MEMWB : MEMRD;
         end
         MEMWB: begin
            regWrC    = 1'b1;
            memToRegC = 1'b1;
            nextState = FETCH;
         end
         MEMWR: begin
            memWriteC = 1'b1;
            iorDC     = 1'b1;
            nextState = MemReady ? FETCH : MEMWR;
         end
         EXEC: begin
            aluSrcAC  = 1'b1;
            nextState = RWB;
         end
         RWB: begin
            regWrC    = 1'b1;
            regDstC   = 1'b1;
            nextState = FETCH;
         end
         IEXEC: begin
            aluSrcAC  = 1'b1;
            aluSrcBC  = 2'b10;
            aluopC    = (Op == OP_ANDI) ? 3'b011 : 3'b010;
            nextState = IWB;
         end
         IWB: begin
            regWrC    = 1'b1;
            nextState = FETCH;
         end
         BRANCH: begin
            aluSrcAC     = 1'b1;
            aluopC       = 3'b100;
            pcWriteCondC = 1'b1;
            pcSourceC    = 1'b1;
            nextState    = FETCH;
         end
         ILLEGAL: begin
            // PC was already bumped in FETCH, so this retires as a NOP.
            illegalC  = 1'b1;
            nextState = FETCH;
         end
         default: begin
            nextState = FETCH;
         end
      endcase
   end

   // Reset gates every strobe so nothing fires while the state sits in FETCH.
   assign PCWrite     = rst_n & pcWriteC;
   assign PCWriteCond = rst_n & pcWriteCondC;
   assign PCSource    = rst_n & pcSourceC;
   assign IorD        = rst_n & iorDC;
   assign MemRead     = rst_n & memReadC;
   assign MemWrite    = rst_n & memWriteC;
   assign IRWrite     = rst_n & irWriteC;
   assign RegDst      = rst_n & regDstC;
   assign RegWr       = rst_n & regWrC;
   assign MemToReg    = rst_n & memToRegC;
   assign AluSrcA     = rst_n & aluSrcAC;
   assign AluSrcB     = rst_n ? aluSrcBC : 2'b00;
   assign Aluop       = rst_n ? aluopC : 3'b000;
   assign Illegal     = rst_n & illegalC;
   assign State       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed scoreboard bench for multicycle_control
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] Op;
   logic       Zero;
   logic       MemReady;
   logic       PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite;
   logic       RegDst, RegWr, MemToReg, AluSrcA, Illegal;
   logic [1:0] AluSrcB;
   logic [2:0] Aluop;
   logic [3:0] State;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [20:0] v;
   } exp_t;

   exp_t sb[$];

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero), .MemReady(MemReady),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .RegWr(RegWr), .MemToReg(MemToReg), .AluSrcA(AluSrcA),
      .AluSrcB(AluSrcB), .Aluop(Aluop), .Illegal(Illegal), .State(State)
   );

   always #5 clk = ~clk;

   function automatic logic [20:0] observed();
      return {State, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
              IRWrite, RegDst, RegWr, MemToReg, AluSrcA, AluSrcB, Aluop, Illegal};
   endfunction

   // Reference output table for each state as described for the controller.
   function automatic logic [20:0] specOut(input logic [3:0] st, input logic mr,
                                           input logic [5:0] op);
      logic pcW, pcWC, pcS, iord, mRd, mWr, irW, rDst, rWr, m2r, srcA, ill;
      logic [1:0] srcB;
      logic [2:0] aop;
      {pcW, pcWC, pcS, iord, mRd, mWr, irW, rDst, rWr, m2r, srcA, ill} = '0;
      srcB = 2'b00;
      aop  = 3'b000;
      case (st)
         4'd0:  begin mRd = 1; srcB = 2'b01; aop = 3'b001; irW = mr; pcW = mr; end
         4'd1:  begin srcB = 2'b11; aop = 3'b001; end
         4'd2:  begin srcA = 1; srcB = 2'b10; aop = 3'b001; end
         4'd3:  begin mRd = 1; iord = 1; end
         4'd4:  begin rWr = 1; m2r = 1; end
         4'd5:  begin mWr = 1; iord = 1; end
         4'd6:  begin srcA = 1; end
         4'd7:  begin rWr = 1; rDst = 1; end
         4'd8:  begin srcA = 1; srcB = 2'b10; aop = (op == 6'b001100) ? 3'b011 : 3'b010; end
         4'd9:  begin rWr = 1; end
         4'd10: begin srcA = 1; aop = 3'b100; pcWC = 1; pcS = 1; end
         4'd11: begin ill = 1; end
         default: ;
      endcase
      return {st, pcW, pcWC, pcS, iord, mRd, mWr, irW, rDst, rWr, m2r, srcA, srcB, aop, ill};
   endfunction

   task automatic compareFront();
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty got=none exp=entry");
      end else begin
         e = sb.pop_front();
         assert (observed() === e.v) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", e.tag, observed(), e.v);
         end
      end
   endtask

   // One cycle: drive MemReady, queue the expected outputs, compare mid-cycle.
   task automatic step(input string tag, input logic [3:0] st, input logic mr);
      exp_t e;
      MemReady = mr;
      e.tag = tag;
      e.v   = specOut(st, mr, Op);
      sb.push_back(e);
      @(negedge clk);
      compareFront();
      @(posedge clk);
      #1;
   endtask

   task automatic expectZero(input string tag);
      exp_t e;
      e.tag = tag;
      e.v   = '0;
      sb.push_back(e);
      compareFront();
   endtask

   initial begin
      rst_n    = 1'b0;
      Op       = 6'b000000;
      Zero     = 1'b0;
      MemReady = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      expectZero("reset_outputs");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      Op = 6'b000000;
      step("rtype_fetch", 4'd0, 1'b1);
      step("rtype_decode", 4'd1, 1'b1);
      step("rtype_exec", 4'd6, 1'b1);
      step("rtype_rwb", 4'd7, 1'b1);

      Op = 6'b100011;
      step("lw_fetch_wait1", 4'd0, 1'b0);
      step("lw_fetch_wait2", 4'd0, 1'b0);
      step("lw_fetch_ready", 4'd0, 1'b1);
      step("lw_decode", 4'd1, 1'b0);
      step("lw_memadr", 4'd2, 1'b0);
      step("lw_memrd_wait1", 4'd3, 1'b0);
      step("lw_memrd_wait2", 4'd3, 1'b0);
      step("lw_memrd_wait3", 4'd3, 1'b0);
      step("lw_memrd_ready", 4'd3, 1'b1);
      step("lw_memwb", 4'd4, 1'b0);

      Op = 6'b101011;
      step("sw_fetch", 4'd0, 1'b1);
      step("sw_decode", 4'd1, 1'b1);
      step("sw_memadr", 4'd2, 1'b1);
      step("sw_memwr", 4'd5, 1'b1);

      for (int z = 0; z < 2; z++) begin
         Op   = 6'b000100;
         Zero = z[0];
         step("beq_fetch", 4'd0, 1'b1);
         step("beq_decode", 4'd1, 1'b1);
         step("beq_branch", 4'd10, 1'b1);
      end

      Op = 6'b001000;
      step("addi_fetch", 4'd0, 1'b1);
      step("addi_decode", 4'd1, 1'b1);
      step("addi_iexec", 4'd8, 1'b1);
      step("addi_iwb", 4'd9, 1'b1);

      Op = 6'b001100;
      step("andi_fetch", 4'd0, 1'b1);
      step("andi_decode", 4'd1, 1'b1);
      step("andi_iexec", 4'd8, 1'b1);
      step("andi_iwb", 4'd9, 1'b1);

      Op = 6'b111111;
      step("ill_fetch", 4'd0, 1'b1);
      step("ill_decode", 4'd1, 1'b1);
      step("ill_illegal", 4'd11, 1'b1);
      step("ill_after", 4'd0, 1'b0);
      step("ill_after_hold", 4'd0, 1'b1);

      Op = 6'b101011;
      step("swrst_decode", 4'd1, 1'b1);
      step("swrst_memadr", 4'd2, 1'b1);
      step("swrst_memwr_wait", 4'd5, 1'b0);
      rst_n = 1'b0;
      #1;
      expectZero("reset_during_memwr");
      @(negedge clk);
      expectZero("reset_held_memwr");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("post_reset_fetch", 4'd0, 1'b0);
      step("post_reset_fetch_ready", 4'd0, 1'b1);
      step("post_reset_decode", 4'd1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
